// File: rtl/frame_checker_if.sv
`timescale 1ns/1ps
// Ingress AXI-Stream sink and 8-bit Avalon-MM register port of the frame checker.
interface frame_checker_if;
    logic [7:0]  writedata;
    logic        write;
    logic        chipselect;
    logic [7:0]  address;
    logic        read;
    logic [7:0]  readdata;
    logic [15:0] ingress_port_tdata;
    logic        ingress_port_tvalid;
    logic        ingress_port_tlast;
    logic        ingress_port_tready;

    modport slave (
        input  writedata, write, chipselect, address, read,
        input  ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
        output readdata, ingress_port_tready
    );

    modport master (
        output writedata, write, chipselect, address, read,
        output ingress_port_tdata, ingress_port_tvalid, ingress_port_tlast,
        input  readdata, ingress_port_tready
    );
endinterface

// File: rtl/frame_checker.sv
`timescale 1ns/1ps
// Frame sink: parses 16-byte header, sums payload, checks length, counts good/bad frames.
// Verdict in the final-beat cycle, readdata 1-cycle registered; tready = control.enable.
module frame_checker #(
    parameter int MAX_LEN      = 254,
    parameter bit EN_RESET_VAL = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    frame_checker_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_DRAIN} state_t;

    typedef struct packed {
        logic len_bad;
        logic long_f;
        logic short_f;
    } err_t;

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t      state, state_nxt;
    logic [7:0]  beat_idx;
    logic [7:0]  hdr     [16];
    logic [7:0]  hdr_nxt [16];
    logic [7:0]  hdr_sh  [16];
    logic [31:0] chk, chk_nxt, chk_sh;
    logic [15:0] frame_count;
    logic [7:0]  err_count;
    err_t        err_q, ev_err;
    logic        enable;
    logic [7:0]  readdata_q, rd_mux;

    logic        beat_acc, hdr_wr, chk_clr, chk_add, ev_good;
    logic [3:0]  widx;
    logic [7:0]  e_last;
    logic        len_bad_in;
    logic        ctl_wr, clr, rd_sel;
    logic        unused_wd;

    assign bus.ingress_port_tready = enable;
    assign bus.readdata            = readdata_q;

    assign beat_acc   = bus.ingress_port_tvalid && enable;
    assign e_last     = 8'd7 + {1'b0, hdr[12][7:1]};
    // Length byte arrives in the upper half of beat 6; judge it before it is stored.
    assign len_bad_in = bus.ingress_port_tdata[8] ||
                        ({1'b0, bus.ingress_port_tdata[15:8]} > MAX_LEN_W);
    assign ctl_wr     = bus.chipselect && bus.write && (bus.address == 8'd24);
    assign clr        = ctl_wr && bus.writedata[1];
    assign rd_sel     = bus.chipselect && bus.read;
    assign unused_wd  = ^bus.writedata[7:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_wr    = 1'b0;
        widx      = {beat_idx[2:0], 1'b0};
        chk_clr   = 1'b0;
        chk_add   = 1'b0;
        ev_good   = 1'b0;
        ev_err    = '0;
        if (beat_acc) begin
            case (state)
                ST_IDLE: begin
                    hdr_wr  = 1'b1;
                    widx    = 4'd0;
                    chk_clr = 1'b1;
                    if (bus.ingress_port_tlast) ev_err.short_f = 1'b1;
                    else                        state_nxt = ST_HEADER;
                end
                ST_HEADER: begin
                    hdr_wr = 1'b1;
                    if (beat_idx == 8'd6 && len_bad_in) begin
                        ev_err.len_bad = 1'b1;
                        state_nxt = bus.ingress_port_tlast ? ST_IDLE : ST_DRAIN;
                    end else if (beat_idx == 8'd7 && hdr[12] == 8'd0) begin
                        if (bus.ingress_port_tlast) begin
                            ev_good   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            ev_err.long_f = 1'b1;
                            state_nxt     = ST_DRAIN;
                        end
                    end else if (bus.ingress_port_tlast) begin
                        ev_err.short_f = 1'b1;
                        state_nxt      = ST_IDLE;
                    end else if (beat_idx == 8'd7) begin
                        state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    chk_add = 1'b1;
                    if (beat_idx == e_last) begin
                        if (bus.ingress_port_tlast) begin
                            ev_good   = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            ev_err.long_f = 1'b1;
                            state_nxt     = ST_DRAIN;
                        end
                    end else if (bus.ingress_port_tlast) begin
                        ev_err.short_f = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (bus.ingress_port_tlast) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Next-cycle header and checksum, so a completing frame captures its own final beat.
    always_comb begin
        hdr_nxt = hdr;
        if (hdr_wr) begin
            hdr_nxt[widx]        = bus.ingress_port_tdata[15:8];
            hdr_nxt[widx + 4'd1] = bus.ingress_port_tdata[7:0];
        end
        chk_nxt = chk;
        if (chk_clr)
            chk_nxt = '0;
        else if (chk_add)
            chk_nxt = chk + {24'd0, bus.ingress_port_tdata[15:8]}
                          + {24'd0, bus.ingress_port_tdata[7:0]};
    end

    always_comb begin
        rd_mux = '0;
        if (bus.address < 8'd16) begin
            rd_mux = hdr_sh[bus.address[3:0]];
        end else begin
            case (bus.address)
                8'd16:   rd_mux = chk_sh[7:0];
                8'd17:   rd_mux = chk_sh[15:8];
                8'd18:   rd_mux = chk_sh[23:16];
                8'd19:   rd_mux = chk_sh[31:24];
                8'd20:   rd_mux = frame_count[7:0];
                8'd21:   rd_mux = frame_count[15:8];
                8'd22:   rd_mux = err_count;
                8'd23:   rd_mux = {4'd0, err_q, (state != ST_IDLE)};
                8'd24:   rd_mux = {7'd0, enable};
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                hdr[i]    <= '0;
                hdr_sh[i] <= '0;
            end
            beat_idx    <= '0;
            chk         <= '0;
            chk_sh      <= '0;
            frame_count <= '0;
            err_count   <= '0;
            err_q       <= '0;
            enable      <= EN_RESET_VAL;
            readdata_q  <= '0;
        end else begin
            hdr <= hdr_nxt;
            chk <= chk_nxt;
            if (beat_acc)
                beat_idx <= (state == ST_IDLE) ? 8'd1 : beat_idx + 8'd1;
            if (ctl_wr)
                enable <= bus.writedata[0];
            // Clear overrides any verdict landing in the same cycle.
            if (clr) begin
                for (int i = 0; i < 16; i++) hdr_sh[i] <= '0;
                chk_sh      <= '0;
                frame_count <= '0;
                err_count   <= '0;
                err_q       <= '0;
            end else if (ev_good) begin
                hdr_sh      <= hdr_nxt;
                chk_sh      <= chk_nxt;
                frame_count <= (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;
                err_q       <= '0;
            end else if (ev_err != '0) begin
                err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
                err_q     <= err_q | ev_err;
            end
            readdata_q <= rd_sel ? rd_mux : 8'd0;
        end
    end
endmodule

// File: tb/tb_frame_checker.sv
`timescale 1ns/1ps
// Directed and randomized frames against a frame-level reference model of frame_checker.
module tb_frame_checker;
    localparam int MAX_LEN      = 254;
    localparam bit EN_RESET_VAL = 1'b1;

    logic clk;
    logic reset;
    frame_checker_if bus ();

    frame_checker #(.MAX_LEN(MAX_LEN), .EN_RESET_VAL(EN_RESET_VAL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fq [$];
    logic [7:0]  exp_hdr [16];
    logic [31:0] exp_chk;
    logic [15:0] exp_fc;
    logic [7:0]  exp_ec;
    logic [2:0]  exp_st;
    logic        exp_en;
    logic [7:0]  d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] wd);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = wd;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] rd);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        @(posedge clk);
        #1;
        rd = bus.readdata;
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] dat, input logic last);
        logic acc;
        if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.ingress_port_tvalid = 1'b0;
            bus.ingress_port_tdata  = 16'($urandom);
            bus.ingress_port_tlast  = 1'($urandom);
        end
        @(negedge clk);
        bus.ingress_port_tvalid = 1'b1;
        bus.ingress_port_tdata  = dat;
        bus.ingress_port_tlast  = last;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (bus.ingress_port_tready) begin
                @(posedge clk);
                acc = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        bus.ingress_port_tvalid = 1'b0;
        chk("beat_accept", 32'(acc), 32'd1);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) exp_hdr[i] = 8'd0;
        exp_chk = '0; exp_fc = '0; exp_ec = '0; exp_st = '0;
    endtask

    // Frame verdict from the length rules: 0 good, 1 short, 2 long, 3 bad length.
    task automatic model_frame();
        int last, len, e, kind;
        logic [15:0] w;
        logic [31:0] sum;
        last = fq.size() - 1;
        kind = 1;
        if (last >= 6) begin
            w   = fq[6];
            len = int'(w[15:8]);
            if ((len % 2) != 0 || len > MAX_LEN) kind = 3;
            else begin
                e    = 7 + len / 2;
                kind = (last < e) ? 1 : ((last == e) ? 0 : 2);
            end
        end
        if (kind == 0) begin
            sum = '0;
            for (int i = 0; i <= last; i++) begin
                w = fq[i];
                if (i < 8) begin
                    exp_hdr[2*i]   = w[15:8];
                    exp_hdr[2*i+1] = w[7:0];
                end else begin
                    sum = sum + 32'(w[15:8]) + 32'(w[7:0]);
                end
            end
            exp_chk = sum;
            if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
            exp_st = '0;
        end else begin
            if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
            if (kind == 1) exp_st[0] = 1'b1;
            if (kind == 2) exp_st[1] = 1'b1;
            if (kind == 3) exp_st[2] = 1'b1;
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < fq.size(); i++) send_beat(fq[i], 1'(i == fq.size() - 1));
        model_frame();
    endtask

    task automatic gen(input logic [7:0] len, input int n);
        logic [7:0] hb [16];
        for (int i = 0; i < 16; i++) hb[i] = 8'($urandom);
        hb[12] = len;
        fq.delete();
        for (int i = 0; i < n; i++) begin
            if (i < 8) fq.push_back({hb[2*i], hb[2*i+1]});
            else       fq.push_back(16'($urandom));
        end
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] rd;
        for (int a = 0; a < 16; a++) begin
            bus_read(8'(a), rd);
            chk($sformatf("%s hdr%0d", tag, a), 32'(rd), 32'(exp_hdr[a]));
        end
        for (int b = 0; b < 4; b++) begin
            bus_read(8'(16 + b), rd);
            chk($sformatf("%s chk%0d", tag, b), 32'(rd), 32'(exp_chk[8*b +: 8]));
        end
        bus_read(8'd20, rd); chk({tag, " fc_lo"}, 32'(rd), 32'(exp_fc[7:0]));
        bus_read(8'd21, rd); chk({tag, " fc_hi"}, 32'(rd), 32'(exp_fc[15:8]));
        bus_read(8'd22, rd); chk({tag, " err_count"}, 32'(rd), 32'(exp_ec));
        bus_read(8'd23, rd); chk({tag, " status"}, 32'(rd), 32'({4'd0, exp_st, 1'b0}));
        bus_read(8'd24, rd); chk({tag, " control"}, 32'(rd), 32'({7'd0, exp_en}));
        bus_read(8'd25, rd); chk({tag, " unmapped"}, 32'(rd), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, " idle_readdata"}, 32'(bus.readdata), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, len, e, n;
        reset = 1'b0;
        bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
        bus.address = '0; bus.writedata = '0;
        bus.ingress_port_tvalid = 1'b0; bus.ingress_port_tdata = '0; bus.ingress_port_tlast = 1'b0;
        model_clear();
        exp_en = EN_RESET_VAL;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("reset tready", 32'(bus.ingress_port_tready), 32'(EN_RESET_VAL));
        check_regs("reset");

        // L=4 reference frame
        fq = {16'h0102, 16'h0304, 16'h0506, 16'h0A0B, 16'h0C0D, 16'h0E0F,
              16'h0400, 16'h0800, 16'h1122, 16'h3344};
        send_frame();
        check_regs("l4");
        bus_read(8'd16, d); chk("l4 chk_b0", 32'(d), 32'h0000_00AA);
        bus_read(8'd0,  d); chk("l4 hdr0", 32'(d), 32'h01);
        bus_read(8'd20, d); chk("l4 fc", 32'(d), 32'd1);
        bus_read(8'd23, d); chk("l4 status", 32'(d), 32'd0);

        // L=0, tlast on beat 7
        gen(8'd0, 8);
        send_frame();
        check_regs("l0");
        bus_read(8'd16, d); chk("l0 chk_b0", 32'(d), 32'd0);
        bus_read(8'd20, d); chk("l0 fc", 32'(d), 32'd2);

        // short: L=4, tlast on beat 8
        gen(8'd4, 9);
        send_frame();
        check_regs("short");
        bus_read(8'd23, d); chk("short status", 32'(d), 32'h02);
        bus_read(8'd20, d); chk("short fc", 32'(d), 32'd2);
        gen(8'd2, 9);
        send_frame();
        bus_read(8'd23, d); chk("good_after_short status", 32'(d), 32'h00);

        // long: L=4, tlast on beat 12
        gen(8'd4, 13);
        send_frame();
        check_regs("long");
        bus_read(8'd23, d); chk("long status", 32'(d), 32'h04);
        bus_read(8'd22, d); chk("long err_count", 32'(d), 32'd2);

        // odd length drained to tlast
        gen(8'd5, 11);
        send_frame();
        check_regs("odd");
        bus_read(8'd23, d); chk("odd status", 32'(d), 32'h0C);

        // clear on the final beat of a good frame
        gen(8'd4, 10);
        for (int i = 0; i < 9; i++) send_beat(fq[i], 1'b0);
        @(negedge clk);
        bus.ingress_port_tvalid = 1'b1; bus.ingress_port_tdata = fq[9]; bus.ingress_port_tlast = 1'b1;
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd24; bus.writedata = 8'h03;
        @(posedge clk);
        #1;
        bus.ingress_port_tvalid = 1'b0; bus.chipselect = 1'b0; bus.write = 1'b0;
        model_clear();
        check_regs("clear_final");
        bus_read(8'd20, d); chk("clear fc", 32'(d), 32'd0);

        // enable dropped mid-payload for 5 cycles
        gen(8'd6, 11);
        for (int i = 0; i < 9; i++) send_beat(fq[i], 1'b0);
        bus_write(8'd24, 8'h00);
        exp_en = 1'b0;
        @(negedge clk);
        bus.ingress_port_tvalid = 1'b1; bus.ingress_port_tdata = fq[9]; bus.ingress_port_tlast = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall tready %0d", i), 32'(bus.ingress_port_tready), 32'd0);
            @(negedge clk);
        end
        bus_read(8'd23, d); chk("stall busy", 32'(d), 32'({4'd0, exp_st, 1'b1}));
        bus_write(8'd24, 8'h01);
        exp_en = 1'b1;
        send_beat(fq[9], 1'b0);
        send_beat(fq[10], 1'b1);
        model_frame();
        check_regs("stall");

        // randomized mix of good, short, long and bad-length frames
        for (int f = 0; f < 40; f++) begin
            k   = $urandom_range(0, 3);
            len = 2 * $urandom_range(0, 20);
            e   = 7 + len / 2;
            case (k)
                0: n = e + 1;
                1: n = $urandom_range(1, e);
                2: n = e + 1 + $urandom_range(1, 3);
                default: begin
                    len = 2 * $urandom_range(0, 127) + 1;
                    n   = $urandom_range(8, 12);
                end
            endcase
            gen(8'(len), n);
            send_frame();
            if ($urandom_range(0, 7) == 0) begin
                bus_write(8'd24, 8'h03);
                model_clear();
            end
            check_regs($sformatf("rnd%0d", f));
        end

        // err_count saturation with single-beat frames
        for (int i = 0; i < 260; i++) begin
            fq = {16'($urandom)};
            send_frame();
        end
        check_regs("sat");
        bus_read(8'd22, d); chk("sat err_count", 32'(d), 32'hFF);

        // async reset in the middle of a payload
        gen(8'd8, 12);
        for (int i = 0; i < 10; i++) send_beat(fq[i], 1'b0);
        bus_write(8'd24, 8'h00);
        chk("pre_reset tready", 32'(bus.ingress_port_tready), 32'd0);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'd22;
        @(posedge clk);
        #2;
        chk("pre_reset readdata", 32'(bus.readdata), 32'(exp_ec));
        reset = 1'b0;
        #1;
        chk("async tready", 32'(bus.ingress_port_tready), 32'(EN_RESET_VAL));
        chk("async readdata", 32'(bus.readdata), 32'd0);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        exp_en = EN_RESET_VAL;
        check_regs("post_reset");
        gen(8'd2, 9);
        send_frame();
        check_regs("post_reset_frame");
        bus_read(8'd20, d); chk("post_reset fc", 32'(d), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_checker.md
Name: frame_checker

Overview:
- Receive-side counterpart of the frame generator: an AXI-Stream sink that accepts 16-bit frame beats, parses the 16-byte header and sums the payload bytes.
- Checks frame length against the header length field and counts good and errored frames.
- Exposes captured header, checksum, counters and status over the same 8-bit Avalon-MM slave map style.
- Sits at the end of the packet-filter datapath so software can compare the generator's and checker's checksums and counts.

Parameters:
MAX_LEN, 254, largest legal payload length in bytes; a header length above this is an error.
EN_RESET_VAL, 1, reset value of control.enable (ingress tready gating).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
writedata  in  8  Avalon write data
write  in  1  Avalon write strobe
chipselect  in  1  Avalon chip select
address  in  8  Avalon register address
read  in  1  Avalon read strobe
readdata  out  8  Avalon read data, registered
ingress_port_tdata  in  16  frame beat; [15:8] is the earlier wire byte
ingress_port_tvalid  in  1  beat valid
ingress_port_tlast  in  1  last beat of frame
ingress_port_tready  out  1  sink ready

Behaviour:
- Reset (reset=0, async) clears everything to 0: FSM=IDLE, all counters, shadows and status, readdata. enable resets to EN_RESET_VAL.
- Handshake:
  - ingress_port_tready = enable, combinational from the register.
  - A beat is accepted only when tvalid && tready.
  - Nothing advances without an accepted beat.
- Beat counter: beat_idx, 8-bit, zeroed at each frame start. Byte offset = 2*beat_idx.
- Header:
  - Beats 0-7 load the live header buffer hdr[0..15]: hdr[2i] = tdata[15:8], hdr[2i+1] = tdata[7:0].
  - L = hdr[12], 8-bit payload byte count; hdr[13] is ignored for length.
  - Expected last beat E = 7 + L/2.
- Checksum: 32-bit running sum, cleared at frame start. Each payload beat (beat_idx >= 8) adds tdata[15:8] + tdata[7:0], both zero-extended. Wraps modulo 2^32.
- FSM:
  - IDLE: an accepted beat latches hdr[0:1], goes to HEADER, beat_idx=1. If that beat carries tlast, it is a short error and the FSM stays in IDLE.
  - HEADER: on beat 6, hdr[12] is known.
    - If hdr[12] is odd or > MAX_LEN, set err_len_bad and go to DRAIN.
    - On beat 7: if tlast and L==0, the frame is good. Otherwise, if L==0 and no tlast, long error -> DRAIN. Otherwise go to PAYLOAD.
    - tlast before beat 7: short error -> IDLE.
  - PAYLOAD:
    - tlast with beat_idx < E: short error -> IDLE.
    - beat_idx == E with tlast: good frame -> IDLE.
    - beat_idx == E without tlast: long error -> DRAIN.
  - DRAIN: discard beats until an accepted tlast, then IDLE. No checksum update.
- Good frame, in the completing cycle:
  - Copy hdr[0..15] into shadow registers; the final beat's bytes are included.
  - Copy the final checksum into chk_shadow.
  - frame_count += 1, 16-bit, saturating at 0xFFFF.
  - Clear status error bits.
- Errored frame: at error detection, err_count += 1 (8-bit, saturating at 0xFF). Set the matching status bit; bits are held until the next good frame or a clear. Shadows are left unchanged.
- Register map (address decode):
  - 0-15 R: header shadow bytes.
  - 16-19 R: chk_shadow bytes 0..3, little-endian.
  - 20-21 R: frame_count low/high.
  - 22 R: err_count.
  - 23 R status: bit0 busy (FSM != IDLE), bit1 err_short, bit2 err_long, bit3 err_len_bad.
  - 24 R/W control: bit0 enable; bit1 clear, write-1 pulse, reads 0.
  - Other addresses: read 0, writes ignored.
- Read timing: readdata is registered with 1-cycle latency and returns the value before any same-cycle update. readdata is 0 whenever there is no chipselect && read.
- Clear:
  - Zeroes frame_count, err_count, status bits and shadows; the FSM is untouched.
  - Clear in the same cycle as a frame completion: clear wins, and all affected values read 0 afterwards.
- Enable deasserted mid-frame: tready=0 stalls; FSM state and checksum are held; the frame resumes when enable returns.

Test Plan:
- L=4, header dst 01..06, src 0A..0F, byte12=0x04, type 0x0800, payload words 0x1122,0x3344, tlast on beat 9 -> frame_count=1, chk 16..19 = AA,00,00,00, hdr shadow byte 0=0x01, status=0.
- L=0, 8 header beats with tlast on beat 7 -> frame_count=1, checksum reads 0.
- L=4 but tlast on beat 8 -> err_count=1, status bit1=1, frame_count and shadows unchanged. A following good frame -> status=0.
- L=4, no tlast at beat 9, tlast at beat 12 -> status bit2=1, err_count=1, beats 10-12 discarded.
  - Odd L=5 -> status bit3=1, drained to tlast.
- Clear:
  - Write 0x03 to addr 24 on a frame's final beat -> counters and shadows read 0.
  - Write enable=0 mid-payload for 5 cycles, then 1 -> tready low during the gap, frame completes with the correct checksum.
- Async reset:
  - Assert reset=0 mid-PAYLOAD between clock edges -> tready=EN_RESET_VAL immediately, all registers read 0.
  - After release, the next frame is parsed from beat 0.
